// File: rtl/telemetry_tx_if.sv
// telemetry_tx_if: byte handshake between the packetizer and the UART transmitter
interface telemetry_tx_if;
  logic trmt;
  logic [7:0] tx_data;
  logic tx_done;
  modport master (output trmt, output tx_data, input tx_done);
  modport slave (input trmt, input tx_data, output tx_done);
endinterface

// File: rtl/telemetry_tx.sv
// telemetry_tx: snapshots telemetry words on a tick or request and streams a checksummed packet to the UART
module telemetry_tx #(
  parameter int NUM_WORDS = 3,
  parameter int PERIOD = 1000000
) (
  input logic clk,
  input logic rst_n,
  input logic en,
  input logic send,
  input logic [16*NUM_WORDS-1:0] words_in,
  telemetry_tx_if.master tx,
  output logic busy,
  output logic pkt_sent,
  output logic [7:0] overrun_cnt
);
  localparam int CW = PERIOD > 1 ? $clog2(PERIOD) : 1;
  localparam logic [4:0] LAST = 5'(2*NUM_WORDS+2);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [16*NUM_WORDS-1:0] shadow;
  logic [4:0] idx, nxt_idx, cur_p, nxt_p;
  logic [7:0] sum, nxt_sum, cur_pay, nxt_pay, nxt_byte;
  logic done_q, tick, trig, rise;
  assign tick = en && (cnt == CW'(PERIOD-1));
  assign trig = tick || send;
  assign rise = tx.tx_done && !done_q;
  assign busy = state != IDLE;
  assign nxt_idx = idx + 5'd1;
  assign cur_p = idx - 5'd2;
  assign nxt_p = idx - 5'd1;
  assign cur_pay = 8'(shadow >> {cur_p[4:1], ~cur_p[0], 3'b000});
  assign nxt_pay = 8'(shadow >> {nxt_p[4:1], ~nxt_p[0], 3'b000});
  assign nxt_sum = sum + ((idx >= 5'd2) ? cur_pay : 8'h00);
  assign nxt_byte = nxt_idx == 5'd1 ? 8'h5A : nxt_idx == LAST ? ~nxt_sum : nxt_pay;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      shadow <= '0;
      idx <= '0;
      sum <= '0;
      done_q <= 1'b0;
      tx.trmt <= 1'b0;
      tx.tx_data <= 8'h00;
      pkt_sent <= 1'b0;
      overrun_cnt <= 8'h00;
    end else begin
      cnt <= (!en || tick) ? '0 : cnt + CW'(1);
      done_q <= tx.tx_done;
      tx.trmt <= 1'b0;
      pkt_sent <= 1'b0;
      if (trig && state != IDLE && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
      case (state)
        IDLE: if (trig) begin
          shadow <= words_in;
          idx <= '0;
          sum <= '0;
          tx.tx_data <= 8'hA5;
          tx.trmt <= 1'b1;
          state <= LOAD;
        end
        LOAD: state <= WAIT;
        WAIT: if (rise) begin
          if (idx == LAST) begin
            pkt_sent <= 1'b1;
            state <= DONE;
          end else begin
            idx <= nxt_idx;
            sum <= nxt_sum;
            tx.tx_data <= nxt_byte;
            tx.trmt <= 1'b1;
            state <= LOAD;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule
